// File: rtl/coin_change_dispenser.sv
// Coin change dispenser: pays a refund out of three coin tubes (5/10/20) greedily,
// one registered eject pulse at a time with a programmable idle gap between pulses.
module coin_change_dispenser #(
    parameter int unsigned GAP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [5:0] amount,
    input  logic       load,
    input  logic [5:0] load5,
    input  logic [5:0] load10,
    input  logic [5:0] load20,
    output logic       drop5,
    output logic       drop10,
    output logic       drop20,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [5:0] remain,
    output logic [5:0] cnt5,
    output logic [5:0] cnt10,
    output logic [5:0] cnt20,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_DROP   = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] COIN5  = 2'd0;
    localparam logic [1:0] COIN10 = 2'd1;
    localparam logic [1:0] COIN20 = 2'd2;
    localparam logic [2:0] GAP_LAST = (GAP == 0) ? 3'd0 : 3'(GAP - 1);

    state_t     state_q, state_d;
    logic [1:0] coin_q, coin_d;
    logic [2:0] gap_cnt_q, gap_cnt_d;
    logic [5:0] remain_q, remain_d;
    logic [5:0] cnt5_q, cnt5_d;
    logic [5:0] cnt10_q, cnt10_d;
    logic [5:0] cnt20_q, cnt20_d;
    logic       drop5_q, drop5_d;
    logic       drop10_q, drop10_d;
    logic       drop20_q, drop20_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       short_q, short_d;

    // State advances on the falling edge so it lines up with the vending FSM.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            coin_q    <= COIN5;
            gap_cnt_q <= 3'd0;
            remain_q  <= 6'd0;
            cnt5_q    <= 6'd0;
            cnt10_q   <= 6'd0;
            cnt20_q   <= 6'd0;
            drop5_q   <= 1'b0;
            drop10_q  <= 1'b0;
            drop20_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            coin_q    <= coin_d;
            gap_cnt_q <= gap_cnt_d;
            remain_q  <= remain_d;
            cnt5_q    <= cnt5_d;
            cnt10_q   <= cnt10_d;
            cnt20_q   <= cnt20_d;
            drop5_q   <= drop5_d;
            drop10_q  <= drop10_d;
            drop20_q  <= drop20_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            short_q   <= short_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        coin_d    = coin_q;
        gap_cnt_d = gap_cnt_q;
        remain_d  = remain_q;
        cnt5_d    = cnt5_q;
        cnt10_d   = cnt10_q;
        cnt20_d   = cnt20_q;
        drop5_d   = 1'b0;
        drop10_d  = 1'b0;
        drop20_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        short_d   = short_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    busy_d   = 1'b1;
                    short_d  = 1'b0;
                    remain_d = amount;
                    state_d  = (amount != 6'd0) ? S_SELECT : S_DONE;
                end else if (load) begin
                    cnt5_d  = load5;
                    cnt10_d = load10;
                    cnt20_d = load20;
                end
            end
            // The guards here are what keep counts and remain from underflowing in DROP.
            S_SELECT: begin
                if (remain_q >= 6'd4 && cnt20_q != 6'd0) begin
                    coin_d  = COIN20;
                    state_d = S_DROP;
                end else if (remain_q >= 6'd2 && cnt10_q != 6'd0) begin
                    coin_d  = COIN10;
                    state_d = S_DROP;
                end else if (remain_q >= 6'd1 && cnt5_q != 6'd0) begin
                    coin_d  = COIN5;
                    state_d = S_DROP;
                end else begin
                    short_d = (remain_q != 6'd0);
                    state_d = S_DONE;
                end
            end
            S_DROP: begin
                case (coin_q)
                    COIN20: begin
                        drop20_d = 1'b1;
                        cnt20_d  = cnt20_q - 6'd1;
                        remain_d = remain_q - 6'd4;
                    end
                    COIN10: begin
                        drop10_d = 1'b1;
                        cnt10_d  = cnt10_q - 6'd1;
                        remain_d = remain_q - 6'd2;
                    end
                    default: begin
                        drop5_d  = 1'b1;
                        cnt5_d   = cnt5_q - 6'd1;
                        remain_d = remain_q - 6'd1;
                    end
                endcase
                if (GAP != 0) begin
                    gap_cnt_d = GAP_LAST;
                    state_d   = S_GAP;
                end else begin
                    state_d = S_SELECT;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 3'd0) begin
                    state_d = S_SELECT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign drop5   = drop5_q;
    assign drop10  = drop10_q;
    assign drop20  = drop20_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign short   = short_q;
    assign remain  = remain_q;
    assign cnt5    = cnt5_q;
    assign cnt10   = cnt10_q;
    assign cnt20   = cnt20_q;
    assign state_o = state_q;

endmodule
